icache_dm: RTL
==============

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter: NSETS, 32, number of direct-mapped lines (power of two).
REQ-002 Parameter: WPB, 4, 32-bit words per line (power of two).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: pc  input  32  fetch address from PC register; word aligned.
REQ-006 Port: rd_en  input  1  fetch stage requests an instruction this cycle.
REQ-007 Port: instr  output  32  instruction to fetch/decode pipeline register.
REQ-008 Port: hit  output  1  instr valid this cycle.
REQ-009 Port: stall  output  1  freeze PC and IF/ID register.
REQ-010 Port: mem_req  output  1  word read request to main memory.
REQ-011 Port: mem_addr  output  32  byte address of requested word.
REQ-012 Port: mem_rdata  input  32  memory read data.
REQ-013 Port: mem_ready  input  1  mem_rdata valid for current mem_addr.

Function
REQ-014 Address split at defaults: offset pc[3:2], index pc[8:4], tag pc[31:9] (23 bits); widths derive from NSETS/WPB.
REQ-015 Storage: per line one valid bit, one tag, WPB data words; registers, no reset on data/tag.
REQ-016 FSM states: IDLE, FILL; no other states.
REQ-017 IDLE lookup is combinational: hit = rd_en & valid[index] & (tag[index]==pc tag); instr = selected word when hit, else 32'h0.
REQ-018 IDLE, rd_en=0: hit=0, stall=0, mem_req=0, no state change.
REQ-019 IDLE, rd_en=1 and miss: stall=1 same cycle; at clock edge latch {tag,index} of pc into miss register, word counter := 0, state := FILL.
REQ-020 FILL: mem_req=1, stall=1, hit=0; mem_addr = {miss tag, miss index, counter, 2'b00}.
REQ-021 FILL, mem_ready=1 at edge: write mem_rdata into word[counter] of miss line, counter increments; mem_ready=0 holds counter and mem_addr.
REQ-022 FILL, mem_ready=1 with counter=WPB-1: write last word, write tag, set valid, state := IDLE; the next cycle re-looks up pc and hits.
REQ-023 Fill always fetches words 0..WPB-1 in order regardless of miss offset.
REQ-024 pc changes during FILL are ignored; fill completes on latched line address.
REQ-025 mem_ready while mem_req=0 is ignored.
REQ-026 Replacement: miss overwrites resident line at index unconditionally; valid bit goes low at FILL entry for that index until fill completes.
REQ-027 Miss-to-hit latency: 1 (miss cycle) + WPB memory handshakes + 0; with mem_ready constant 1, stall high exactly 5 cycles at defaults.
REQ-028 mem_req, mem_addr, stall driven from state/registers only in FILL (no combinational path from mem_ready).

Reset
REQ-029 reset asserted: state := IDLE, all valid bits := 0, counter := 0 immediately, independent of clk.
REQ-030 Outputs during/after reset: hit=0, stall=0 (unless rd_en miss), mem_req=0, mem_addr=0, instr=0.
REQ-031 Reset mid-FILL aborts the fill; partially written line stays invalid.

Verification
REQ-032 Reset, rd_en=1, pc=0x00400008, mem_ready=1 -> stall 5 cycles, mem_addr 0x00400000,04,08,0C, then hit=1, instr=word at 0x00400008.
REQ-033 After REQ-032, pc=0x00400000..0x0040000C consecutive -> hit=1 each cycle, stall=0, mem_req=0.
REQ-034 pc=0x00400200 (index 0, new tag) -> refill of 0x00400200..0C; subsequent pc=0x00400000 misses again.
REQ-035 mem_ready pulses every 3rd cycle -> mem_addr held stable between pulses, stall lasts 1+12 cycles, correct data stored.
REQ-036 Reset after 2 of 4 fill words, then same pc -> miss, full 4-word refill re-issued from word 0.
REQ-037 rd_en=0 for 10 cycles with varying pc -> mem_req=0, stall=0, hit=0 throughout.

Source files
------------

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with a combinational lookup and a
// word-serial line fill from main memory.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (clears valid bits, aborts fill)
//   pc         word-aligned fetch address
//   rd_en      fetch request this cycle
//   instr      instruction word (32'h0 unless hit)
//   hit        instr valid this cycle
//   stall      freeze PC and IF/ID register
//   mem_req    word read request to main memory (FILL only)
//   mem_addr   byte address of requested word (0 outside FILL)
//   mem_rdata  memory read data
//   mem_ready  mem_rdata valid for current mem_addr
//
// Parameters
//   NSETS      number of lines (power of two, >= 2)
//   WPB        32-bit words per line (power of two, >= 2)
module icache_dm #(
  parameter int NSETS = 32,
  parameter int WPB   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        rd_en,
  output logic [31:0] instr,
  output logic        hit,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int OFF_W = $clog2(WPB);
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WPB - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [NSETS-1:0]   valid_q;

  // Tag and data storage carry no reset; the valid bits alone decide residency.
  logic [TAG_W-1:0]   tag_q  [NSETS];
  logic [31:0]        data_q [NSETS][WPB];

  logic [OFF_W-1:0]   pc_off;
  logic [IDX_W-1:0]   pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic               lookup_hit;
  logic               miss_start;
  logic               fill_we;
  logic               fill_done;

  assign pc_off     = pc[OFF_W+1:2];
  assign pc_idx     = pc[IDX_W+OFF_W+1:OFF_W+2];
  assign pc_tag     = pc[31:IDX_W+OFF_W+2];
  assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  // Next-state and outputs. In FILL, stall/mem_req/mem_addr depend only on
  // registered state; mem_ready steers the next state and nothing else.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    hit        = 1'b0;
    instr      = 32'h0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = 32'h0;
    miss_start = 1'b0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_en) begin
          if (lookup_hit) begin
            hit   = 1'b1;
            instr = data_q[pc_idx][pc_off];
          end else begin
            stall      = 1'b1;
            miss_start = 1'b1;
            miss_tag_d = pc_tag;
            miss_idx_d = pc_idx;
            cnt_d      = '0;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        stall    = 1'b1;
        mem_addr = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
        if (mem_ready) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      // The victim line is invalidated as soon as its refill starts, so an
      // aborted fill can never leave a half-written line marked valid.
      if (miss_start) valid_q[pc_idx]     <= 1'b0;
      if (fill_done)  valid_q[miss_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)   data_q[miss_idx_q][cnt_q] <= mem_rdata;
    if (fill_done) tag_q[miss_idx_q]         <= miss_tag_q;
  end

endmodule
